// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads and buffers returned words in order
// for the decoder. Redirects flush the buffer and discard reads still in flight.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req_valid,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_req_ready,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_resp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    output logic        o_fetch_error
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = 8;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_fetch_pc;
    logic            r_fetch_error;
    logic [CW-1:0]   r_outst;
    logic [DW-1:0]   r_drop;

    logic [31:0]     r_fifo_data [FIFO_DEPTH];
    logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [31:0]     r_pcq [FIFO_DEPTH];
    logic [PW-1:0]   r_pcq_wr;
    logic [PW-1:0]   r_pcq_rd;

    logic            w_misaligned;
    logic            w_space;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_resp_live;
    logic            w_resp_keep;
    logic            w_push;
    logic            w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);
    // Credit rule: buffered words plus reads in flight never exceed the buffer size.
    assign w_space      = ({1'b0, r_count} + {1'b0, r_outst}) < (CW + 1)'(FIFO_DEPTH);
    assign w_req_fire   = w_req_valid && i_mem_req_ready;
    // A response with nothing pending (e.g. a read issued before reset) is ignored.
    assign w_resp_live  = i_mem_resp_valid && ((r_drop != '0) || (r_outst != '0));
    assign w_resp_keep  = w_resp_live && (r_drop == '0) && !i_redirect_valid;
    assign w_push       = w_resp_keep;
    assign w_pop        = o_instr_valid && i_instr_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_req_valid = !i_rst && !i_redirect_valid && w_space;
                if (i_redirect_valid && w_misaligned) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (i_redirect_valid && !w_misaligned) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_fetch_error <= 1'b0;
            r_outst       <= '0;
            r_drop        <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else if (i_redirect_valid) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
            r_outst  <= '0;
            // Everything still in flight becomes stale; a response landing now is one of them.
            r_drop   <= r_drop + DW'(r_outst) - DW'(w_resp_live);
            if (w_misaligned) begin
                r_fetch_error <= 1'b1;
            end else begin
                r_fetch_pc <= i_redirect_pc;
            end
        end else begin
            if (w_req_fire) begin
                r_pcq[r_pcq_wr] <= r_fetch_pc;
                r_pcq_wr        <= ptr_inc(r_pcq_wr);
                r_fetch_pc      <= r_fetch_pc + 32'd4;
            end
            if (w_resp_live && (r_drop != '0)) begin
                r_drop <= r_drop - DW'(1);
            end
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= i_mem_resp_data;
                r_fifo_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
                r_pcq_rd              <= ptr_inc(r_pcq_rd);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_outst <= r_outst + CW'(w_req_fire) - CW'(w_resp_keep);
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

    assign o_mem_req_valid = w_req_valid;
    assign o_mem_req_addr  = r_fetch_pc;
    assign o_instr_valid   = !i_rst && (r_count != '0);
    assign o_instr         = o_instr_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign o_instr_pc      = o_instr_valid ? r_fifo_pc[r_rd_ptr] : '0;
    assign o_fetch_error   = r_fetch_error && !i_rst;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a latency-configurable memory model returns
// ~addr for every read, so each delivered word can be tied back to its PC.
module tb_instruction_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_mem_req_valid;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_req_ready = 1'b1;
    logic        i_mem_resp_valid = 1'b0;
    logic [31:0] i_mem_resp_data = '0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b1;
    logic        o_fetch_error;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int lat    = 1;
    int t_first_resp  = -1;
    int t_first_valid = -1;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] acc_q     [$];
    logic [31:0] cons_pc   [$];
    logic [31:0] cons_data [$];

    instruction_fetch dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_data  (i_mem_resp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_instr_ready    (i_instr_ready),
        .o_fetch_error    (o_fetch_error)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    // Decoder monitor, then memory response, then request capture, all mid-cycle.
    always @(negedge i_clk) begin
        if (o_instr_valid && i_instr_ready) begin
            cons_pc.push_back(o_instr_pc);
            cons_data.push_back(o_instr);
        end
        if (!i_rst && o_instr_valid && t_first_valid < 0) t_first_valid = cyc;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_data  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            i_mem_resp_valid = 1'b0;
            i_mem_resp_data  = '0;
        end
        if (!i_rst && i_mem_resp_valid && t_first_resp < 0) t_first_resp = cyc;
        if (o_mem_req_valid && i_mem_req_ready) begin
            pend_addr.push_back(o_mem_req_addr);
            pend_due.push_back(cyc + lat);
            acc_q.push_back(o_mem_req_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic chk_cons(input string tag, input int idx, input logic [31:0] pc);
        chk({tag, "_pc"},   (cons_pc.size() > idx)   ? cons_pc[idx]   : 32'hBAD0_BAD0, pc);
        chk({tag, "_data"}, (cons_data.size() > idx) ? cons_data[idx] : 32'hBAD0_BAD0, ~pc);
    endtask

    task automatic chk_acc(input string tag, input int idx, input logic [31:0] addr);
        chk(tag, (acc_q.size() > idx) ? acc_q[idx] : 32'hBAD0_BAD0, addr);
    endtask

    task automatic wait_cons(input int n, input int budget);
        int k = 0;
        while (cons_pc.size() < n && k < budget) begin
            @(negedge i_clk);
            #1;
            k++;
        end
        chk("wait_cons", 32'(cons_pc.size() >= n), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc, input bit exp_req);
        @(posedge i_clk);
        #1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = pc;
        acc_q.delete();
        @(negedge i_clk);
        chk("redir_req_quiet", 32'(o_mem_req_valid), 32'd0);
        @(posedge i_clk);
        #1;
        i_redirect_valid = 1'b0;
        cons_pc.delete();
        cons_data.delete();
        @(negedge i_clk);
        chk("redir_iv_low", 32'(o_instr_valid), 32'd0);
        if (exp_req) chk("redir_req_addr", o_mem_req_valid ? o_mem_req_addr : 32'hDEAD_BEEF, pc);
    endtask

    initial begin
        // 1: reset, latency 1, sequential fetch
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req_valid", 32'(o_mem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_fetch_error", 32'(o_fetch_error), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        acc_q.delete();
        cons_pc.delete();
        cons_data.delete();
        wait_cons(3, 50);
        for (int i = 0; i < 3; i++) begin
            chk_acc("seq_addr", i, 32'(4 * i));
            chk_cons("seq", i, 32'(4 * i));
        end
        chk("resp_to_valid", 32'(t_first_valid - t_first_resp), 32'd1);

        // 2: decoder stalled -> only two reads, head held
        i_instr_ready = 1'b0;
        do_redirect(32'h40, 1'b1);
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        chk("stall_nreads", 32'(acc_q.size()), 32'd2);
        chk_acc("stall_addr1", 1, 32'h44);
        chk("stall_valid", 32'(o_instr_valid), 32'd1);
        chk("stall_pc", o_instr_pc, 32'h40);
        chk("stall_instr", o_instr, ~32'h40);

        // 3: latency 3, redirect with two reads in flight
        lat = 3;
        do_redirect(32'h80, 1'b1);
        @(posedge i_clk);
        do_redirect(32'h100, 1'b1);
        i_instr_ready = 1'b1;
        wait_cons(2, 60);
        chk_cons("drop_first", 0, 32'h100);
        chk_cons("drop_second", 1, 32'h104);

        // 4: misaligned redirect halts, aligned one resumes, error sticky
        lat = 1;
        do_redirect(32'h102, 1'b0);
        chk("mis_error", 32'(o_fetch_error), 32'd1);
        repeat (8) @(posedge i_clk);
        @(negedge i_clk);
        chk("halt_nreads", 32'(acc_q.size()), 32'd0);
        do_redirect(32'h200, 1'b1);
        wait_cons(2, 40);
        chk("resume_error", 32'(o_fetch_error), 32'd1);
        chk_cons("resume", 0, 32'h200);
        chk_cons("resume2", 1, 32'h204);

        // 5: PC wrap, then request held while memory not ready
        do_redirect(32'hFFFF_FFFC, 1'b1);
        wait_cons(2, 40);
        chk_acc("wrap_addr0", 0, 32'hFFFF_FFFC);
        chk_acc("wrap_addr1", 1, 32'h0000_0000);
        chk_cons("wrap_a", 0, 32'hFFFF_FFFC);
        chk_cons("wrap_b", 1, 32'h0000_0000);
        i_mem_req_ready = 1'b0;
        do_redirect(32'h300, 1'b1);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        chk("hold_valid", 32'(o_mem_req_valid), 32'd1);
        chk("hold_addr", o_mem_req_addr, 32'h300);
        @(posedge i_clk);
        #1;
        i_mem_req_ready = 1'b1;
        wait_cons(1, 40);
        chk_cons("hold_first", 0, 32'h300);

        // 6: reset with one word buffered and one read in flight
        lat = 3;
        i_instr_ready = 1'b0;
        do_redirect(32'h400, 1'b1);
        @(posedge i_clk);
        #1;
        i_mem_req_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_mem_req_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst6_req_valid", 32'(o_mem_req_valid), 32'd0);
        chk("rst6_error", 32'(o_fetch_error), 32'd0);
        @(negedge i_clk);
        chk("rst6_iv", 32'(o_instr_valid), 32'd0);
        chk("rst6_instr", o_instr, 32'd0);
        chk("rst6_pc", o_instr_pc, 32'd0);
        chk("rst6_addr", o_mem_req_addr, 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        lat = 1;
        i_instr_ready = 1'b1;
        acc_q.delete();
        cons_pc.delete();
        cons_data.delete();
        wait_cons(2, 40);
        chk_acc("rst6_first_addr", 0, 32'h0);
        chk_cons("rst6_a", 0, 32'h0);
        chk_cons("rst6_b", 1, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
